// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the button debounce block
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int count_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flip-flop synchroniser chain
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronised, debounced push-button with press/release/long strobes
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd10_000,
    parameter int unsigned LONG_CYCLES     = 32'd1_000_000,
    parameter int          SYNC_STAGES     = 2,
    parameter logic        BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int CW = count_width(DEBOUNCE_CYCLES);
    localparam int HW = count_width(LONG_CYCLES);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = (LONG_CYCLES == 0) ? '0 : HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = '1;

    logic          btn_polarised;
    logic          s;
    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_next;
    logic          long_done;
    logic          long_hit;

    assign btn_polarised = BTN_ACTIVE_LOW ? ~i_btn : i_btn;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (i_clk),
        .resetn (i_rst_n),
        .d      (btn_polarised),
        .q      (s)
    );

    // hold advances on every pressed-level sample, including the one that ends a release glitch
    assign hold_next = (hold == HOLD_MAX) ? hold : hold + HW'(1);
    assign long_hit  = (LONG_CYCLES != 0) && (hold == LONG_LAST) && !long_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= RELEASED;
            cnt       <= '0;
            hold      <= '0;
            long_done <= 1'b0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= PRESSED;
                        o_level <= 1'b1;
                        o_press <= 1'b1;
                        hold    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end else begin
                        hold <= hold_next;
                        if (long_hit) begin
                            o_long    <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                        hold  <= hold_next;
                        if (long_hit) begin
                            o_long    <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end else if (cnt == DEB_LAST) begin
                        state     <= RELEASED;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                        long_done <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 10;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic level, press, rel, lng;

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .SYNC_STAGES     (S),
        .BTN_ACTIVE_LOW  (1'b0)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn     (btn),
        .o_level   (level),
        .o_press   (press),
        .o_release (rel),
        .o_long    (lng)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: pad history, debounced level, run of disagreeing samples, pressed-sample count
    logic hist[$];
    logic m_level = 1'b0;
    logic m_press = 1'b0;
    logic m_rel = 1'b0;
    logic m_long = 1'b0;
    int   m_run = 0;
    int   m_hold = 0;

    int edge_n = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    int press_edge = -1, rel_edge = -1, long_edge = -1;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic b, input logic r);
        logic smp;
        btn   = b;
        rst_n = r;
        @(posedge clk);
        edge_n++;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!r) begin
            hist.delete();
            m_level = 1'b0;
            m_run   = 0;
            m_hold  = 0;
        end else begin
            hist.push_back(b);
            smp = (hist.size() > S) ? hist[hist.size() - 1 - S] : 1'b0;
            if (m_level && smp) begin
                m_hold++;
                if (m_hold == L) m_long = 1'b1;
            end
            if (smp != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = smp;
                    m_run   = 0;
                    if (smp) begin
                        m_press = 1'b1;
                        m_hold  = 0;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        check_bit("level", level, m_level);
        check_bit("press", press, m_press);
        check_bit("release", rel, m_rel);
        check_bit("long", lng, m_long);
        if (press) begin n_press++; press_edge = edge_n; end
        if (rel)   begin n_rel++;   rel_edge   = edge_n; end
        if (lng)   begin n_long++;  long_edge  = edge_n; end
    endtask

    task automatic hold_btn(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b, 1'b1);
    endtask

    initial begin
        int base;
        int p0, r0, l0;
        logic pat [6];

        // Reset state
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        hold_btn(1'b0, 4);

        // Clean press: edge 0 is the first edge with the pad high
        base = edge_n + 1;
        p0 = n_press; r0 = n_rel; l0 = n_long;
        hold_btn(1'b1, 8);
        check_int("press_latency", press_edge - base, 5);
        check_int("press_count", n_press - p0, 1);
        check_int("press_no_release", n_rel - r0, 0);

        // Clean release
        base = edge_n + 1;
        hold_btn(1'b0, 8);
        check_int("release_latency", rel_edge - base, 5);
        check_int("release_count", n_rel - r0, 1);

        // Bounce pattern then steady press
        p0 = n_press;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) tick(pat[i], 1'b1);
        hold_btn(1'b1, 8);
        check_int("bounce_press_count", n_press - p0, 1);
        hold_btn(1'b0, 8);

        // Short glitch never reaches the level
        p0 = n_press; r0 = n_rel;
        hold_btn(1'b1, 3);
        hold_btn(1'b0, 8);
        check_int("glitch_press", n_press - p0, 0);
        check_int("glitch_release", n_rel - r0, 0);

        // Long press, release, long press again
        l0 = n_long; r0 = n_rel;
        hold_btn(1'b1, 36);
        check_int("long_count", n_long - l0, 1);
        check_int("long_delay", long_edge - press_edge, L);
        hold_btn(1'b0, 8);
        check_int("long_release", n_rel - r0, 1);
        hold_btn(1'b1, 20);
        check_int("long_again", n_long - l0, 2);
        hold_btn(1'b0, 8);

        // Two-cycle release glitch delays long by two cycles
        l0 = n_long; r0 = n_rel;
        hold_btn(1'b1, 8);
        hold_btn(1'b0, 2);
        hold_btn(1'b1, 20);
        check_int("rglitch_no_release", n_rel - r0, 0);
        check_bit("rglitch_level", level, 1'b1);
        check_int("rglitch_long_delay", long_edge - press_edge, L + 2);
        check_int("rglitch_long_count", n_long - l0, 1);

        // Reset while pressed and still held
        r0 = n_rel; p0 = n_press;
        tick(1'b1, 1'b0);
        check_bit("midreset_level", level, 1'b0);
        base = edge_n + 1;
        hold_btn(1'b1, 8);
        check_int("midreset_no_release", n_rel - r0, 0);
        check_int("midreset_press_count", n_press - p0, 1);
        check_int("midreset_press_latency", press_edge - base, 5);
        hold_btn(1'b0, 8);

        // Random runs and occasional resets against the reference
        for (int k = 0; k < 120; k++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 39) == 0) tick(b, 1'b0);
            hold_btn(b, len);
        end
        hold_btn(1'b1, 30);
        hold_btn(1'b0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
